// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index register width: ceil(log2(n)), never below 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_chunk_compare.sv
// Combinational unsigned magnitude compare of one W-bit slice.
module chunk_compare #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt_c,
  output logic         gt_c,
  output logic         eq_c
);

  assign lt_c = (a < b);
  assign gt_c = (a > b);
  assign eq_c = (a == b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk first.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish at the first differing chunk.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              signed_q;
  logic [IDXW-1:0]   idx_q;
  logic              decided_q;
  logic              dec_gt_q;

  logic [CHUNK-1:0]  a_sl_c;
  logic [CHUNK-1:0]  b_sl_c;
  logic              lt_c;
  logic              gt_c;
  logic              eq_c;
  logic              res_dec_c;
  logic              res_gt_c;
  logic              res_lt_c;
  logic              exit_c;

  // Select the current slice; flipping both sign bits maps two's complement onto unsigned order.
  always_comb begin
    a_sl_c = '0;
    b_sl_c = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl_c = a_q[i*CHUNK +: CHUNK];
        b_sl_c = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (signed_q && (idx_q == TOP_IDX)) begin
      a_sl_c[CHUNK-1] = ~a_sl_c[CHUNK-1];
      b_sl_c[CHUNK-1] = ~b_sl_c[CHUNK-1];
    end
  end

  chunk_compare #(
    .W (CHUNK)
  ) u_chunk_compare (
    .a    (a_sl_c),
    .b    (b_sl_c),
    .lt_c (lt_c),
    .gt_c (gt_c),
    .eq_c (eq_c)
  );

  // An earlier decision always wins over the current slice.
  assign res_dec_c = decided_q | ~eq_c;
  assign res_gt_c  = decided_q ? dec_gt_q  : gt_c;
  assign res_lt_c  = decided_q ? ~dec_gt_q : lt_c;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign exit_c = (idx_q == '0) || !eq_c;
`else
  assign exit_c = (idx_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_lt_b    <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            signed_q  <= signed_mode;
            idx_q     <= TOP_IDX;
            decided_q <= 1'b0;
            dec_gt_q  <= 1'b0;
            a_lt_b    <= 1'b0;
            a_gt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            busy      <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (!decided_q && !eq_c) begin
            decided_q <= 1'b1;
            dec_gt_q  <= gt_c;
          end
          if (exit_c) begin
            a_lt_b  <= res_lt_c;
            a_gt_b  <= res_gt_c;
            a_eq_b  <= ~res_dec_c;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_serial_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, a_lt_b, a_gt_b, a_eq_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [2:0] flags;  // {lt, gt, eq}
    int         base;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int LAT_TOP = 1;
  localparam int LAT_MID = 2;
`else
  localparam int LAT_TOP = 4;
  localparam int LAT_MID = 4;
`endif

  serial_magnitude_comparator #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_lt_b      (a_lt_b),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_flags"}, {29'd0, a_lt_b, a_gt_b, a_eq_b}, {29'd0, e.flags});
        chk({e.name, "_latency"}, cyc - e.base, e.lat);
      end
    end
  end

  // Drive start for one edge from the current negedge and queue the expectation.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                       input logic [2:0] ef, input int lat, input string nm);
    exp_t e;
    a = ia;
    b = ib;
    signed_mode = is;
    start = 1'b1;
    e.flags = ef;
    e.base  = cyc + 1;
    e.lat   = lat;
    e.name  = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Waits for done while checking that flags stay cleared during the run.
  task automatic wait_done_flags_zero();
    int n = 0;
    while (!done && n < 64) begin
      chk("flags_zero_busy", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'd0);
      @(negedge clk);
      n++;
    end
    if (!done) chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int dc0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // Directed compares: {lt, gt, eq}
    issue(16'h1234, 16'h1234, 1'b0, 3'b001, 4,       "uns_eq");
    wait_idle();
    repeat (3) @(negedge clk);
    chk("eq_hold_idle", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'd1);
    issue(16'h8000, 16'h7FFF, 1'b0, 3'b010, LAT_TOP, "uns_top");
    wait_idle();
    issue(16'h8000, 16'h7FFF, 1'b1, 3'b100, LAT_TOP, "sgn_top");
    wait_idle();
    issue(16'hFFF1, 16'hFFF2, 1'b1, 3'b100, 4,       "sgn_low");
    wait_idle();
    issue(16'h0010, 16'hFFF0, 1'b1, 3'b010, LAT_TOP, "sgn_pos_neg");
    wait_idle();
    issue(16'h1200, 16'h1300, 1'b0, 3'b100, LAT_MID, "uns_mid");
    wait_idle();

    // Start held for six edges with operands changed after capture.
    dc0 = done_cnt;
    a = 16'h0001;
    b = 16'h0002;
    signed_mode = 1'b0;
    start = 1'b1;
    begin
      exp_t e;
      e.flags = 3'b100;
      e.base  = cyc + 1;
      e.lat   = 4;
      e.name  = "held_start";
      sb.push_back(e);
    end
    @(negedge clk);
    a = 16'h0003;
    b = 16'h0001;
    repeat (5) @(negedge clk);
    start = 1'b0;
    chk("held_start_not_requeued", {31'd0, busy}, 32'd0);
    chk("held_start_done_count", done_cnt - dc0, 32'd1);
    issue(16'h0003, 16'h0001, 1'b0, 3'b010, 4, "after_held");
    wait_idle();

    // Reset at edge 2 of a run aborts it.
    dc0 = done_cnt;
    a = 16'h1234;
    b = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {27'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: second start in the IDLE cycle right after done.
    issue(16'h0005, 16'h0003, 1'b0, 3'b010, 4, "b2b_first");
    wait_done_flags_zero();
    @(negedge clk);
    chk("b2b_idle_hold", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b010);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    issue(16'h00F0, 16'h00F0, 1'b0, 3'b001, 4, "b2b_second");
    wait_done_flags_zero();
    wait_idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
